wide_add_sequencer: RTL
=======================

Name: wide_add_sequencer

Overview:
Multi-word adder/subtractor controller that time-multiplexes one 16-bit ripple carry adder over WORDS 16-bit slices, least-significant slice first, chaining the carry through a register between cycles. Provides WORDS*16-bit add/sub without a WORDS*16-bit combinational carry chain. Sits between an operand producer (valid/ready request side) and a result consumer (valid/ready response side).

Parameters:
WORDS, 4, number of 16-bit slices per operand; legal range 1..16; operand width = 16*WORDS.

Ports:
clk  input  1  clock; all state updates on rising edge.
rst_n  input  1  synchronous active-low reset, sampled on rising edge of clk.
start_valid  input  1  request valid; operands and op stable while high.
start_ready  output  1  block can accept a request (IDLE only).
op_sub  input  1  0: a+b+cin; 1: a+~b+cin (cin=1 gives a-b).
a  input  16*WORDS  operand A.
b  input  16*WORDS  operand B.
cin  input  1  initial carry into slice 0.
res_valid  output  1  result available.
res_ready  input  1  consumer accepts result.
sum  output  16*WORDS  result, low 16*WORDS bits.
cout  output  1  carry out of top slice.
overflow  output  1  signed (two's complement) overflow of the full-width operation.

Behaviour:
- Reset (rst_n=0 at a rising edge): state IDLE; start_ready=1, res_valid=0, sum=0, cout=0, overflow=0; slice counter, carry and operand registers cleared. Reset overrides all other activity in any state, including mid-RUN and DONE.
- States: IDLE, RUN, DONE.
- IDLE: start_ready=1. On start_valid&&start_ready, capture a, b (pre-inverted when op_sub=1) and cin into internal registers. Clear the slice counter and go to RUN.
- RUN: start_ready=0. Each cycle k (0..WORDS-1), the adder sees A slice k, effective-B slice k and the carry register. Write sum slice k and load the carry register with the slice carry out. Increment the counter.
- RUN exit: on the cycle k=WORDS-1, also load cout and overflow, then go to DONE.
- overflow = (A msb == effective-B msb) && (sum msb != A msb).
- Latency: a request accepted at edge N gives res_valid=1 after edge N+WORDS. With WORDS=1, RUN lasts exactly one cycle.
- DONE: res_valid=1. sum, cout and overflow are held stable until res_ready=1. On res_valid&&res_ready, go to IDLE; res_valid drops and start_ready rises at the same edge.
- There is no same-cycle result-accept/new-request overlap. Minimum request spacing is WORDS+2 cycles.
- sum slices not yet written during RUN hold their previous values (0 after reset). Consumers only sample when res_valid=1.
- start_valid while busy is ignored and not queued. Inputs a, b, op_sub and cin are don't-care outside the accept cycle.
- Slice counter width is clog2(WORDS), minimum 1 bit. No wrap occurs because the exit happens at WORDS-1.
- Arithmetic is modulo 2^(16*WORDS); carry beyond the top slice appears only on cout.

Decomposition:
- Shared package wide_add_pkg holds:
  - SLICE_W=16;
  - state enum (IDLE=2'd0, RUN=2'd1, DONE=2'd2);
  - a function computing the counter width from WORDS.
- One sub-module instance: the existing 16-bit ripple carry adder (RippleCarryAdder16Bit). It is driven by the slice-select mux outputs and the carry register.
- The sequencer itself holds only the FSM, counter, operand/result registers and slice muxing; it contains no adder logic of its own.

Test Plan:
- Carry ripple across all slices (WORDS=4): a=0xFFFF_FFFF_FFFF_FFFF, b=0x1, cin=0, op_sub=0 -> sum=0x0, cout=1, overflow=0; res_valid rises exactly 4 edges after accept.
- Signed overflow: a=0x7FFF_FFFF_FFFF_FFFF, b=0x1, cin=0 -> sum=0x8000_0000_0000_0000, cout=0, overflow=1.
- Subtract with borrow across slice boundary: op_sub=1, cin=1, a=0x0000_0000_0001_0000, b=0x1 -> sum=0x0000_0000_0000_FFFF, cout=1 (no borrow), overflow=0.
- Backpressure: after the result, hold res_ready=0 for 5 cycles with start_valid=1.
  - Required: start_ready=0 and sum/cout/overflow unchanged throughout.
  - Then res_ready=1 for one cycle -> IDLE, start_ready=1 and the new request is accepted next edge.
- Reset mid-operation: assert rst_n=0 for one edge during RUN at k=2.
  - Required next cycle: res_valid=0, sum=0, start_ready=1.
  - Then a=0x1234_5678_9ABC_DEF0, b=0x1111_1111_1111_1111, cin=0 -> sum=0x2345_6789_ABCD_F001, cout=0.
- WORDS=1 instance: a=0xFFFF, b=0xFFFF, cin=1 -> sum=0xFFFF, cout=1, overflow=0; res_valid rises 1 edge after accept.

Source files
------------

// File: rtl/wide_add_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// wide_add_pkg
// Shared definitions for the wide add/sub sequencer: slice width, FSM state
// encoding and the slice-counter width helper.
// No ports (package).
// -----------------------------------------------------------------------------
package wide_add_pkg;

  localparam int SLICE_W = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Counter must be at least one bit wide even for a single-slice build.
  function automatic int cnt_width(input int words);
    return (words <= 1) ? 1 : $clog2(words);
  endfunction

endpackage

// File: rtl/wide_add_sequencer_if.sv
// -----------------------------------------------------------------------------
// wide_add_sequencer_if
// Request/response bundle between an operand producer / result consumer
// (master) and the sequencer (slave).
//   start_valid/start_ready : request handshake, a/b/op_sub/cin qualify it
//   res_valid/res_ready     : response handshake, sum/cout/overflow qualify it
//
// Handshake rule (both channels): a transfer happens on a rising clk edge
// where valid and ready are both 1. The sender keeps its payload stable while
// valid is high; ready may be any function of the receiver's state.
// -----------------------------------------------------------------------------
interface wide_add_sequencer_if
  import wide_add_pkg::*;
#(
  parameter int WORDS = 4
);
  localparam int W = SLICE_W * WORDS;

  logic         start_valid;
  logic         start_ready;
  logic         op_sub;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         res_valid;
  logic         res_ready;
  logic [W-1:0] sum;
  logic         cout;
  logic         overflow;

  modport master (
    output start_valid, op_sub, a, b, cin, res_ready,
    input  start_ready, res_valid, sum, cout, overflow
  );

  modport slave (
    input  start_valid, op_sub, a, b, cin, res_ready,
    output start_ready, res_valid, sum, cout, overflow
  );

endinterface

// File: rtl/wide_add_sequencer_rca.sv
// -----------------------------------------------------------------------------
// RippleCarryAdder16Bit
// Plain 16-bit ripple carry adder, one full adder per bit.
//   i_a, i_b : 16-bit addends
//   i_cin    : carry in
//   o_sum    : 16-bit sum
//   o_cout   : carry out of bit 15
// -----------------------------------------------------------------------------
module RippleCarryAdder16Bit
  import wide_add_pkg::*;
(
  input  logic [SLICE_W-1:0] i_a,
  input  logic [SLICE_W-1:0] i_b,
  input  logic               i_cin,
  output logic [SLICE_W-1:0] o_sum,
  output logic               o_cout
);

  logic w_carry;

  always_comb begin
    o_sum   = '0;
    w_carry = i_cin;
    for (int i = 0; i < SLICE_W; i++) begin
      o_sum[i] = i_a[i] ^ i_b[i] ^ w_carry;
      w_carry  = (i_a[i] & i_b[i]) | (w_carry & (i_a[i] ^ i_b[i]));
    end
    o_cout = w_carry;
  end

endmodule

// File: rtl/wide_add_sequencer.sv
// -----------------------------------------------------------------------------
// wide_add_sequencer
// Computes a 16*WORDS-bit add or subtract by pushing one 16-bit slice per
// cycle through a single ripple carry adder, LSB slice first, with the carry
// held in a register between slices.
//   clk         : clock, rising edge
//   rst_n       : synchronous active-low reset
//   bus         : request/response interface (slave side)
//   o_dbg_state : current FSM state
// -----------------------------------------------------------------------------
module wide_add_sequencer
  import wide_add_pkg::*;
#(
  parameter int WORDS = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  wide_add_sequencer_if.slave   bus,
  output state_t                o_dbg_state
);

  localparam int          W     = SLICE_W * WORDS;
  localparam int          CNT_W = cnt_width(WORDS);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WORDS - 1);

  state_t             r_state;
  state_t             w_next_state;
  logic [CNT_W-1:0]   r_cnt;
  logic [W-1:0]       r_a;
  logic [W-1:0]       r_b;       // effective B, already inverted for subtract
  logic               r_carry;
  logic [W-1:0]       r_sum;
  logic               r_cout;
  logic               r_ovf;

  logic [SLICE_W-1:0] w_a_slice;
  logic [SLICE_W-1:0] w_b_slice;
  logic [SLICE_W-1:0] w_slice_sum;
  logic               w_slice_cout;
  logic               w_start_ready;
  logic               w_res_valid;
  logic               w_last;

  assign w_last = (r_cnt == LAST);

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next_state;
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (bus.start_valid) w_next_state = RUN;
      RUN:     if (w_last)          w_next_state = DONE;
      DONE:    if (bus.res_ready)   w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    w_start_ready = 1'b0;
    w_res_valid   = 1'b0;
    case (r_state)
      IDLE:    w_start_ready = 1'b1;
      DONE:    w_res_valid   = 1'b1;
      default: ;
    endcase
  end

  // ---------------- slice select ----------------
  always_comb begin
    w_a_slice = '0;
    w_b_slice = '0;
    for (int i = 0; i < WORDS; i++) begin
      if (r_cnt == CNT_W'(i)) begin
        w_a_slice = r_a[i*SLICE_W +: SLICE_W];
        w_b_slice = r_b[i*SLICE_W +: SLICE_W];
      end
    end
  end

  RippleCarryAdder16Bit u_rca (
    .i_a    (w_a_slice),
    .i_b    (w_b_slice),
    .i_cin  (r_carry),
    .o_sum  (w_slice_sum),
    .o_cout (w_slice_cout)
  );

  // ---------------- datapath ----------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt   <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_carry <= 1'b0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.start_valid) begin
            r_a     <= bus.a;
            r_b     <= bus.op_sub ? ~bus.b : bus.b;
            r_carry <= bus.cin;
            r_cnt   <= '0;
          end
        end
        RUN: begin
          for (int i = 0; i < WORDS; i++) begin
            if (r_cnt == CNT_W'(i)) r_sum[i*SLICE_W +: SLICE_W] <= w_slice_sum;
          end
          r_carry <= w_slice_cout;
          if (w_last) begin
            // Final slice: its sum MSB is the full-width sign bit.
            r_cout <= w_slice_cout;
            r_ovf  <= (r_a[W-1] == r_b[W-1]) && (w_slice_sum[SLICE_W-1] != r_a[W-1]);
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.start_ready = w_start_ready;
  assign bus.res_valid   = w_res_valid;
  assign bus.sum         = r_sum;
  assign bus.cout        = r_cout;
  assign bus.overflow    = r_ovf;
  assign o_dbg_state     = r_state;

endmodule
